game_sequencer: RTL

//  Top-level game-flow controller for chipinvaders. Sequences the attract, play, death, wave-clear
//  and game-over phases; gates the cannon/laser/alien-formation datapaths via enables and reset

---
 rtl/chipinvaders_pkg.sv | 27 ++
 rtl/frame_tick_gen.sv | 30 +++
 rtl/game_sequencer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/chipinvaders_pkg.sv
// Shared types and helpers for the chipinvaders game-flow blocks.
// Game phases, datapath widths and the frame-timer load helper.
package chipinvaders_pkg;

  localparam int SCORE_W = 16;
  localparam int TIMER_W = 8;

  typedef enum logic [2:0] {
    ATTRACT    = 3'd0,
    PLAY       = 3'd1,
    DYING      = 3'd2,
    WAVE_CLEAR = 3'd3,
    GAME_OVER  = 3'd4
  } game_phase_e;

  // A phase lasting N frames loads N-1 and leaves when the count reads 0; 0 frames behaves as 1.
  function automatic logic [TIMER_W-1:0] timer_load(input int unsigned frames);
    if (frames <= 1) begin
      return '0;
    end else if (frames > (1 << TIMER_W)) begin
      return '1;
    end else begin
      return TIMER_W'(frames - 1);
    end
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Brings the pixel-clock vsync into the clk domain and emits one clk-wide pulse
// per frame, on the cycle after the synchronised rising edge.
module frame_tick_gen (
  input  logic clk,
  input  logic rst_n,
  input  logic vsync,
  output logic frame_tick
);

  logic [1:0] r_sync;
  logic       r_prev;
  logic       r_tick;

  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values;
  // blocking here would collapse the synchroniser chain into a single stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], vsync};
      r_prev <= r_sync[1];
      r_tick <= r_sync[1] & ~r_prev;
    end
  end

  assign frame_tick = r_tick;

endmodule

// File: rtl/game_sequencer.sv
// Game-flow controller: steps attract/play/dying/wave-clear/game-over once per frame,
// gates the play datapaths and owns lives, wave, score and hi-score.
module game_sequencer
  import chipinvaders_pkg::*;
#(
  parameter int unsigned LIVES_INIT      = 3,
  parameter int unsigned MAX_WAVE        = 15,
  parameter int unsigned SCORE_PER_ALIEN = 10,
  parameter int unsigned DEATH_FRAMES    = 90,
  parameter int unsigned WAVE_FRAMES     = 60,
  parameter int unsigned OVER_FRAMES     = 180
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               vsync,
  input  logic               btn_start,
  input  logic               cannon_hit,
  input  logic               alien_killed,
  input  logic               aliens_cleared,
  input  logic               aliens_landed,
  output logic               frame_tick,
  output game_phase_e        phase,
  output logic               game_active,
  output logic               formation_reset,
  output logic               cannon_reset,
  output logic [2:0]         lives,
  output logic [3:0]         wave,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] hi_score
);

  localparam int SUM_W = SCORE_W + 1;
  localparam logic [TIMER_W-1:0] DEATH_LOAD = timer_load(DEATH_FRAMES);
  localparam logic [TIMER_W-1:0] WAVE_LOAD  = timer_load(WAVE_FRAMES);
  localparam logic [TIMER_W-1:0] OVER_LOAD  = timer_load(OVER_FRAMES);

  logic               w_frame_tick;
  logic [1:0]         r_btn_sync;
  logic               r_btn_prev;
  logic               w_start;
  logic               r_hit_flag, r_land_flag;
  logic               w_hit, w_landed;

  game_phase_e        r_phase, w_phase_next;
  logic [TIMER_W-1:0] r_timer, w_timer_next;
  logic [2:0]         r_lives, w_lives_next, w_lives_dec;
  logic [3:0]         r_wave, w_wave_next, w_wave_inc;
  logic [SCORE_W-1:0] r_score, r_hi_score, w_hi_next, w_hi_max;
  logic [SUM_W-1:0]   w_score_sum;
  logic               w_score_clear;
  logic               r_form_rst, w_form_rst_next;
  logic               r_cannon_rst, w_cannon_rst_next;

  frame_tick_gen u_frame_tick_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .vsync      (vsync),
    .frame_tick (w_frame_tick)
  );

  // Button is resynchronised, then edge-detected only at frame rate so bounce within a frame is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btn_sync <= '0;
      r_btn_prev <= 1'b0;
    end else begin
      r_btn_sync <= {r_btn_sync[0], btn_start};
      if (w_frame_tick) r_btn_prev <= r_btn_sync[1];
    end
  end

  assign w_start = w_frame_tick & r_btn_sync[1] & ~r_btn_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_flag  <= 1'b0;
      r_land_flag <= 1'b0;
    end else if (w_frame_tick || (r_phase != PLAY)) begin
      r_hit_flag  <= 1'b0;
      r_land_flag <= 1'b0;
    end else begin
      if (cannon_hit)    r_hit_flag  <= 1'b1;
      if (aliens_landed) r_land_flag <= 1'b1;
    end
  end

  // An event arriving on the tick cycle itself is decided at that tick rather than lost.
  assign w_hit       = r_hit_flag | cannon_hit;
  assign w_landed    = r_land_flag | aliens_landed;
  assign w_lives_dec = (r_lives == 3'd0) ? 3'd0 : r_lives - 3'd1;
  assign w_wave_inc  = (r_wave >= 4'(MAX_WAVE)) ? 4'(MAX_WAVE) : r_wave + 4'd1;
  assign w_hi_max    = (r_score > r_hi_score) ? r_score : r_hi_score;
  assign w_score_sum = {1'b0, r_score} + SUM_W'(SCORE_PER_ALIEN);

  // NOTE: every combinational output is given a default before the case so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_phase_next      = r_phase;
    w_timer_next      = r_timer;
    w_lives_next      = r_lives;
    w_wave_next       = r_wave;
    w_hi_next         = r_hi_score;
    w_score_clear     = 1'b0;
    w_form_rst_next   = 1'b0;
    w_cannon_rst_next = 1'b0;
    if (w_frame_tick) begin
      unique case (r_phase)
        ATTRACT: begin
          if (w_start) begin
            w_phase_next      = PLAY;
            w_lives_next      = 3'(LIVES_INIT);
            w_wave_next       = 4'd0;
            w_score_clear     = 1'b1;
            w_form_rst_next   = 1'b1;
            w_cannon_rst_next = 1'b1;
          end
        end
        PLAY: begin
          if (w_hit) begin
            w_lives_next = w_lives_dec;
            if (w_lives_dec == 3'd0) begin
              w_phase_next = GAME_OVER;
              w_timer_next = OVER_LOAD;
              w_hi_next    = w_hi_max;
            end else begin
              w_phase_next = DYING;
              w_timer_next = DEATH_LOAD;
            end
          end else if (w_landed) begin
            w_lives_next = 3'd0;
            w_phase_next = GAME_OVER;
            w_timer_next = OVER_LOAD;
            w_hi_next    = w_hi_max;
          end else if (aliens_cleared) begin
            w_phase_next = WAVE_CLEAR;
            w_timer_next = WAVE_LOAD;
          end
        end
        DYING: begin
          if (r_timer == '0) begin
            w_phase_next      = PLAY;
            w_cannon_rst_next = 1'b1;
          end else begin
            w_timer_next = r_timer - 1'b1;
          end
        end
        WAVE_CLEAR: begin
          if (r_timer == '0) begin
            w_phase_next      = PLAY;
            w_wave_next       = w_wave_inc;
            w_form_rst_next   = 1'b1;
            w_cannon_rst_next = 1'b1;
          end else begin
            w_timer_next = r_timer - 1'b1;
          end
        end
        GAME_OVER: begin
          if (r_timer == '0) w_phase_next = ATTRACT;
          else               w_timer_next = r_timer - 1'b1;
        end
        default: w_phase_next = ATTRACT;
      endcase
    end
  end

  // Reset pulses are registered alongside the phase so both appear on the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase      <= ATTRACT;
      r_timer      <= '0;
      r_lives      <= 3'd0;
      r_wave       <= 4'd0;
      r_hi_score   <= '0;
      r_form_rst   <= 1'b0;
      r_cannon_rst <= 1'b0;
    end else begin
      r_phase      <= w_phase_next;
      r_timer      <= w_timer_next;
      r_lives      <= w_lives_next;
      r_wave       <= w_wave_next;
      r_hi_score   <= w_hi_next;
      r_form_rst   <= w_form_rst_next;
      r_cannon_rst <= w_cannon_rst_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_score <= '0;
    end else if (w_score_clear) begin
      r_score <= '0;
    end else if (alien_killed && (r_phase == PLAY)) begin
      r_score <= w_score_sum[SCORE_W] ? '1 : w_score_sum[SCORE_W-1:0];
    end
  end

  assign frame_tick      = w_frame_tick;
  assign phase           = r_phase;
  assign game_active     = (r_phase == PLAY);
  assign formation_reset = r_form_rst;
  assign cannon_reset    = r_cannon_rst;
  assign lives           = r_lives;
  assign wave            = r_wave;
  assign score           = r_score;
  assign hi_score        = r_hi_score;

endmodule
